// File: rtl/gbt_rx_pattern_checker.sv
// Checks the GBT RX motor-data word against the TX counter pattern (two equal 32-bit halves, +1 per frame).
// Optional first-error capture ports/registers are built when GBT_CHK_ERR_CAPTURE_EN is defined.
module gbt_rx_pattern_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int ERRCNT_W   = 32
) (
    input  logic                clk_ik,
    input  logic                rstn_ir,
    input  logic                clear_i,
    input  logic                los_i,
    input  logic                valid_i,
    input  logic [63:0]         data_i,
    output logic                locked_o,
    output logic                error_o,
    output logic [ERRCNT_W-1:0] err_cnt_o,
    output logic [31:0]         frame_cnt_o,
    output logic [1:0]          state_o
`ifdef GBT_CHK_ERR_CAPTURE_EN
    ,
    output logic                first_err_vld_o,
    output logic [31:0]         first_err_exp_o,
    output logic [63:0]         first_err_rcv_o
`endif
);

    // Frame interface: valid_i alone qualifies data_i for one cycle; there is no
    // backpressure, so every valid_i=1 cycle is a frame that must be consumed.

    typedef enum logic [1:0] {
        ST_LOS     = 2'b00,
        ST_SEARCH  = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [7:0] LOCK_V   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_V = 8'(UNLOCK_CNT);

    state_t              state_q, state_d;
    logic [7:0]          good_run_q, good_run_d;
    logic [7:0]          bad_run_q, bad_run_d;
    logic [31:0]         prev_q, prev_d;
    logic                seeded_q, seeded_d;
    logic                error_q, error_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]         frame_cnt_q, frame_cnt_d;

    logic                halves_eq;
    logic [31:0]         exp_word;
    logic                seq_ok;
    logic                frame_good;
    logic                bad_hit;
    logic                frame_hit;

    assign halves_eq  = (data_i[63:32] == data_i[31:0]);
    assign exp_word   = prev_q + 32'd1;
    assign seq_ok     = (data_i[31:0] == exp_word);
    assign frame_good = halves_eq & seq_ok;

    // Lock FSM and run counters; LOS overrides any frame arriving in the same cycle.
    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        prev_d     = prev_q;
        seeded_d   = seeded_q;
        bad_hit    = 1'b0;
        frame_hit  = 1'b0;

        if (los_i) begin
            state_d    = ST_LOS;
            good_run_d = 8'd0;
            bad_run_d  = 8'd0;
            seeded_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOS: begin
                    state_d = ST_SEARCH;
                end

                ST_SEARCH: begin
                    if (valid_i) begin
                        if (!halves_eq) begin
                            good_run_d = 8'd0;
                            seeded_d   = 1'b0;
                        end else if (!seeded_q || !seq_ok) begin
                            prev_d     = data_i[31:0];
                            good_run_d = 8'd1;
                            seeded_d   = 1'b1;
                        end else begin
                            prev_d     = data_i[31:0];
                            good_run_d = good_run_q + 8'd1;
                            if ((good_run_q + 8'd1) == LOCK_V) begin
                                state_d   = ST_LOCKED;
                                bad_run_d = 8'd0;
                            end
                        end
                    end
                end

                ST_LOCKED: begin
                    if (valid_i) begin
                        frame_hit = 1'b1;
                        // Free-run the reference so one corrupted word costs exactly one error.
                        prev_d    = exp_word;
                        if (frame_good) begin
                            bad_run_d = 8'd0;
                        end else begin
                            bad_hit   = 1'b1;
                            bad_run_d = bad_run_q + 8'd1;
                            if ((bad_run_q + 8'd1) == UNLOCK_V) begin
                                state_d    = ST_SEARCH;
                                good_run_d = 8'd0;
                                seeded_d   = 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_LOS;
                end
            endcase
        end
    end

    // Statistics: clear has priority over a same-cycle increment; error pulse is unaffected by clear.
    always_comb begin
        error_d     = bad_hit;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (clear_i) begin
            err_cnt_d   = '0;
            frame_cnt_d = 32'd0;
        end else begin
            if (bad_hit && (err_cnt_q != {ERRCNT_W{1'b1}}))
                err_cnt_d = err_cnt_q + 1'b1;
            if (frame_hit)
                frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            state_q     <= ST_LOS;
            good_run_q  <= 8'd0;
            bad_run_q   <= 8'd0;
            prev_q      <= 32'd0;
            seeded_q    <= 1'b0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            prev_q      <= prev_d;
            seeded_q    <= seeded_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef GBT_CHK_ERR_CAPTURE_EN
    logic        cap_vld_q, cap_vld_d;
    logic [31:0] cap_exp_q, cap_exp_d;
    logic [63:0] cap_rcv_q, cap_rcv_d;

    // Only the first mismatch after reset/clear is kept; clear beats a same-cycle capture.
    always_comb begin
        cap_vld_d = cap_vld_q;
        cap_exp_d = cap_exp_q;
        cap_rcv_d = cap_rcv_q;
        if (clear_i) begin
            cap_vld_d = 1'b0;
            cap_exp_d = 32'd0;
            cap_rcv_d = 64'd0;
        end else if (bad_hit && !cap_vld_q) begin
            cap_vld_d = 1'b1;
            cap_exp_d = exp_word;
            cap_rcv_d = data_i;
        end
    end

    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            cap_vld_q <= 1'b0;
            cap_exp_q <= 32'd0;
            cap_rcv_q <= 64'd0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_exp_q <= cap_exp_d;
            cap_rcv_q <= cap_rcv_d;
        end
    end

    assign first_err_vld_o = cap_vld_q;
    assign first_err_exp_o = cap_exp_q;
    assign first_err_rcv_o = cap_rcv_q;
`endif

    assign locked_o    = (state_q == ST_LOCKED);
    assign error_o     = error_q;
    assign err_cnt_o   = err_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// Directed bench for gbt_rx_pattern_checker: lock, single error, unlock/relock, wrap, LOS, clear.
// Capture checks are compiled when GBT_CHK_ERR_CAPTURE_EN is defined.
module tb_gbt_rx_pattern_checker;

    logic        clk_ik;
    logic        rstn_ir;
    logic        clear_i;
    logic        los_i;
    logic        valid_i;
    logic [63:0] data_i;
    logic        locked_o;
    logic        error_o;
    logic [31:0] err_cnt_o;
    logic [31:0] frame_cnt_o;
    logic [1:0]  state_o;
`ifdef GBT_CHK_ERR_CAPTURE_EN
    logic        first_err_vld_o;
    logic [31:0] first_err_exp_o;
    logic [63:0] first_err_rcv_o;
`endif

    int checks = 0;
    int errors = 0;
    logic err_seen;

    gbt_rx_pattern_checker #(
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4),
        .ERRCNT_W   (32)
    ) dut (
        .clk_ik      (clk_ik),
        .rstn_ir     (rstn_ir),
        .clear_i     (clear_i),
        .los_i       (los_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .err_cnt_o   (err_cnt_o),
        .frame_cnt_o (frame_cnt_o),
        .state_o     (state_o)
`ifdef GBT_CHK_ERR_CAPTURE_EN
        ,
        .first_err_vld_o (first_err_vld_o),
        .first_err_exp_o (first_err_exp_o),
        .first_err_rcv_o (first_err_rcv_o)
`endif
    );

    // Clock
    initial clk_ik = 1'b0;
    always #5 clk_ik = ~clk_ik;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic clr);
        @(negedge clk_ik);
        valid_i = v;
        data_i  = d;
        clear_i = clr;
        @(posedge clk_ik);
        #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic frame(input logic [31:0] w);
        drive(1'b1, {w, w}, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        rstn_ir = 1'b0;
        clear_i = 1'b0;
        los_i   = 1'b0;
        valid_i = 1'b0;
        data_i  = 64'd0;
        err_seen = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_ik);
        #1;
        chk("rst_state", 64'(state_o), 64'h0);
        chk("rst_locked", 64'(locked_o), 64'h0);
        chk("rst_error", 64'(error_o), 64'h0);
        chk("rst_errcnt", 64'(err_cnt_o), 64'h0);
        chk("rst_framecnt", 64'(frame_cnt_o), 64'h0);

        @(negedge clk_ik);
        rstn_ir = 1'b1;
        @(posedge clk_ik);
        #1;
        chk("los_to_search", 64'(state_o), 64'h1);

        // Lock on 5..12
        for (int i = 5; i < 12; i++) frame(32'(i));
        chk("not_locked_7", 64'(locked_o), 64'h0);
        chk("search_7", 64'(state_o), 64'h1);
        frame(32'd12);
        chk("locked_8", 64'(locked_o), 64'h1);
        chk("state_locked", 64'(state_o), 64'h2);
        chk("lock_errcnt", 64'(err_cnt_o), 64'h0);
        chk("lock_framecnt", 64'(frame_cnt_o), 64'h0);

        for (int i = 13; i <= 16; i++) frame(32'(i));
        chk("good_error", 64'(error_o), 64'h0);
        chk("good_framecnt", 64'(frame_cnt_o), 64'h4);

        // Single corrupted frame (expected 0x11)
        drive(1'b1, 64'h00000010_00000011, 1'b0);
        chk("single_error", 64'(error_o), 64'h1);
        chk("single_errcnt", 64'(err_cnt_o), 64'h1);
        chk("single_framecnt", 64'(frame_cnt_o), 64'h5);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("cap1_vld", 64'(first_err_vld_o), 64'h1);
        chk("cap1_exp", 64'(first_err_exp_o), 64'h11);
        chk("cap1_rcv", first_err_rcv_o, 64'h00000010_00000011);
`endif
        frame(32'h12);
        chk("recover_error", 64'(error_o), 64'h0);
        chk("recover_locked", 64'(locked_o), 64'h1);
        chk("recover_errcnt", 64'(err_cnt_o), 64'h1);
        chk("recover_framecnt", 64'(frame_cnt_o), 64'h6);

        // Clear counters, then four bad frames force unlock
        drive(1'b0, 64'd0, 1'b1);
        chk("clr_errcnt", 64'(err_cnt_o), 64'h0);
        chk("clr_framecnt", 64'(frame_cnt_o), 64'h0);
        chk("clr_state", 64'(state_o), 64'h2);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("clr_cap_vld", 64'(first_err_vld_o), 64'h0);
`endif
        for (int k = 0; k < 3; k++) frame(32'hDEADBEEF);
        chk("bad3_state", 64'(state_o), 64'h2);
        chk("bad3_errcnt", 64'(err_cnt_o), 64'h3);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("cap2_exp", 64'(first_err_exp_o), 64'h13);
        chk("cap2_rcv", first_err_rcv_o, 64'hDEADBEEF_DEADBEEF);
`endif
        frame(32'hDEADBEEF);
        chk("bad4_state", 64'(state_o), 64'h1);
        chk("bad4_locked", 64'(locked_o), 64'h0);
        chk("bad4_errcnt", 64'(err_cnt_o), 64'h4);
        chk("bad4_framecnt", 64'(frame_cnt_o), 64'h4);

        for (int i = 'h17; i <= 'h1D; i++) frame(32'(i));
        chk("relock_7", 64'(locked_o), 64'h0);
        frame(32'h1E);
        chk("relock_8", 64'(locked_o), 64'h1);

        // LOS pulse of 3 cycles with a garbage frame during it
        los_i = 1'b1;
        drive(1'b1, 64'h00000BAD_0000001F, 1'b0);
        chk("los_state", 64'(state_o), 64'h0);
        chk("los_locked", 64'(locked_o), 64'h0);
        chk("los_error", 64'(error_o), 64'h0);
        drive(1'b0, 64'd0, 1'b0);
        drive(1'b0, 64'd0, 1'b0);
        los_i = 1'b0;
        drive(1'b0, 64'd0, 1'b0);
        chk("los_release", 64'(state_o), 64'h1);
        for (int i = 0; i < 7; i++) frame(32'(i));
        chk("los_relock_7", 64'(locked_o), 64'h0);
        frame(32'd7);
        chk("los_relock_8", 64'(locked_o), 64'h1);
        chk("los_errcnt", 64'(err_cnt_o), 64'h4);
        chk("los_framecnt", 64'(frame_cnt_o), 64'h4);

        // Lock just below the wrap point, then cross it
        los_i = 1'b1;
        drive(1'b0, 64'd0, 1'b0);
        los_i = 1'b0;
        drive(1'b0, 64'd0, 1'b0);
        v = 32'hFFFFFFF6;
        for (int i = 0; i < 8; i++) begin
            frame(v);
            v = v + 32'd1;
        end
        chk("wrap_locked", 64'(locked_o), 64'h1);
        for (int i = 0; i < 4; i++) begin
            frame(v);
            err_seen = err_seen | error_o;
            v = v + 32'd1;
        end
        chk("wrap_no_error", 64'(err_seen), 64'h0);
        chk("wrap_framecnt", 64'(frame_cnt_o), 64'h8);
        chk("wrap_errcnt", 64'(err_cnt_o), 64'h4);

        // Clear coincident with a bad frame (expected 2)
        drive(1'b1, 64'h00000005_00000002, 1'b1);
        chk("clrbad_error", 64'(error_o), 64'h1);
        chk("clrbad_errcnt", 64'(err_cnt_o), 64'h0);
        chk("clrbad_framecnt", 64'(frame_cnt_o), 64'h0);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("clrbad_cap_vld", 64'(first_err_vld_o), 64'h0);
`endif
        drive(1'b1, 64'h00000007_00000003, 1'b0);
        chk("post_clr_error", 64'(error_o), 64'h1);
        chk("post_clr_errcnt", 64'(err_cnt_o), 64'h1);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("cap3_vld", 64'(first_err_vld_o), 64'h1);
        chk("cap3_exp", 64'(first_err_exp_o), 64'h3);
        chk("cap3_rcv", first_err_rcv_o, 64'h00000007_00000003);
`endif
        frame(32'd4);
        chk("post_clr_good", 64'(error_o), 64'h0);
        chk("post_clr_locked", 64'(locked_o), 64'h1);
        chk("post_clr_framecnt", 64'(frame_cnt_o), 64'h2);
        drive(1'b1, 64'h00000009_00000005, 1'b0);
        chk("second_errcnt", 64'(err_cnt_o), 64'h2);
`ifdef GBT_CHK_ERR_CAPTURE_EN
        chk("cap_hold_exp", 64'(first_err_exp_o), 64'h3);
        chk("cap_hold_rcv", first_err_rcv_o, 64'h00000007_00000003);
`endif

        // Reset while locked
        @(negedge clk_ik);
        rstn_ir = 1'b0;
        @(posedge clk_ik);
        #1;
        chk("midrst_state", 64'(state_o), 64'h0);
        chk("midrst_locked", 64'(locked_o), 64'h0);
        chk("midrst_errcnt", 64'(err_cnt_o), 64'h0);
        chk("midrst_framecnt", 64'(frame_cnt_o), 64'h0);
        chk("midrst_error", 64'(error_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
